// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit (IDLE/PREP/RUN/FIX).
// Define MULDIV_SIGNED_EN to honour the sign input; otherwise every operation is unsigned.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] opa, opb, m, acc, quo, hi_reg, lo_reg;
  logic [WIDTH-1:0] mag_a, mag_b, diff, res_hi, res_lo;
  logic [WIDTH:0]   sum, shifted;
  logic [CW-1:0]    cnt;
  logic             op_lat, zero_div, ge;

`ifdef MULDIV_SIGNED_EN
  logic                 sign_lat, neg_hi, neg_lo, neg_a, neg_b;
  logic [2*WIDTH-1:0]   prod_fix;

  assign neg_a = sign_lat & opa[WIDTH-1];
  assign neg_b = sign_lat & opb[WIDTH-1];
  assign mag_a = neg_a ? -opa : opa;
  assign mag_b = neg_b ? -opb : opb;
  assign prod_fix = neg_lo ? -{acc, quo} : {acc, quo};
  assign res_hi = op_lat ? (neg_hi ? -acc : acc) : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = op_lat ? (neg_lo ? -quo : quo) : prod_fix[WIDTH-1:0];
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign mag_a  = opa;
  assign mag_b  = opb;
  assign res_hi = acc;
  assign res_lo = quo;
`endif

  // One radix-2 step: shift-add (multiply) or restoring shift-subtract (divide).
  always_comb begin
    sum     = quo[0] ? ({1'b0, acc} + {1'b0, m}) : {1'b0, acc};
    shifted = {acc, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, m});
    diff    = shifted[WIDTH-1:0] - m;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (op && (b == '0)) ? FIX : PREP;
      PREP:    state_next = RUN;
      RUN:     if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIX);
    div0 = (state == FIX) && zero_div;
    hi   = ((state == FIX) && !zero_div) ? res_hi : hi_reg;
    lo   = ((state == FIX) && !zero_div) ? res_lo : lo_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opa      <= '0;
      opb      <= '0;
      m        <= '0;
      acc      <= '0;
      quo      <= '0;
      cnt      <= '0;
      op_lat   <= 1'b0;
      zero_div <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
`ifdef MULDIV_SIGNED_EN
      sign_lat <= 1'b0;
      neg_hi   <= 1'b0;
      neg_lo   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          opa      <= a;
          opb      <= b;
          op_lat   <= op;
          zero_div <= op && (b == '0);
`ifdef MULDIV_SIGNED_EN
          sign_lat <= sign;
`endif
        end
        PREP: begin
          acc <= '0;
          cnt <= CW'(WIDTH);
          m   <= op_lat ? mag_b : mag_a;
          quo <= op_lat ? mag_a : mag_b;
`ifdef MULDIV_SIGNED_EN
          neg_hi <= neg_a;
          neg_lo <= neg_a ^ neg_b;
`endif
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (op_lat) begin
            acc <= ge ? diff : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
          end else begin
            acc <= sum[WIDTH:1];
            quo <= {sum[0], quo[WIDTH-1:1]};
          end
        end
        FIX: if (!zero_div) begin
          hi_reg <= res_hi;
          lo_reg <= res_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (WIDTH=32).
// Expected values follow MULDIV_SIGNED_EN so the bench suits either build.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start, op, sign;
  logic [W-1:0] a, b;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;
  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .sign(sign),
    .a(a), .b(b), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Issue one operation; lat = cycles from the start-sampling edge (counted as 1) to done, -1 on timeout.
  task automatic do_op(input logic o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat);
    @(negedge clock);
    op = o; sign = s; a = x; b = y; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (done) begin lat = n + 1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if ({busy, done, div0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, div0}); end
    checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    start = 1'b1; a = 32'd3; b = 32'd5;
    @(posedge clock); #1 start = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority busy got %b want 0", busy); end
  endtask

  task automatic test_mul;
    logic [W-1:0] va[4], vb[4], eh[4], el[4];
    logic         vs[4];
    int           lat;
    vs[0] = 1'b1; va[0] = 32'd7;        vb[0] = 32'hFFFFFFFD;
    vs[1] = 1'b0; va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; eh[1] = 32'hFFFFFFFE; el[1] = 32'h1;
    vs[2] = 1'b1; va[2] = 32'hFFFFFFFB; vb[2] = 32'hFFFFFFFA;
    vs[3] = 1'b0; va[3] = 32'h12345678; vb[3] = 32'h10;       eh[3] = 32'h1;        el[3] = 32'h23456780;
`ifdef MULDIV_SIGNED_EN
    eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFEB;
    eh[2] = 32'h0;        el[2] = 32'h1E;
`else
    eh[0] = 32'h6;        el[0] = 32'hFFFFFFEB;
    eh[2] = 32'hFFFFFFF5; el[2] = 32'h1E;
`endif
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, vs[i], va[i], vb[i], lat);
      checks++; if (lat !== 34) begin errors++; $display("FAIL mul%0d_latency got %0d want 34", i, lat); end
      checks++; if (hi !== eh[i] || lo !== el[i]) begin errors++; $display("FAIL mul%0d_result got %h_%h want %h_%h", i, hi, lo, eh[i], el[i]); end
      checks++; if (busy !== 1'b1 || div0 !== 1'b0) begin errors++; $display("FAIL mul%0d_flags busy/div0 got %b%b want 10", i, busy, div0); end
      @(negedge clock);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mul%0d_end busy/done got %b%b want 00", i, busy, done); end
    end
  endtask

  task automatic test_div;
    logic [W-1:0] va[5], vb[5], eh[5], el[5];
    logic         vs[5];
    int           lat;
    vs[0] = 1'b1; va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;
    vs[1] = 1'b0; va[1] = 32'hFFFFFFF9; vb[1] = 32'd2;        eh[1] = 32'h1;  el[1] = 32'h7FFFFFFC;
    vs[2] = 1'b1; va[2] = 32'd7;        vb[2] = 32'hFFFFFFFE;
    vs[3] = 1'b1; va[3] = 32'h80000000; vb[3] = 32'hFFFFFFFF;
    vs[4] = 1'b0; va[4] = 32'h451;      vb[4] = 32'h20;       eh[4] = 32'h11; el[4] = 32'h22;
`ifdef MULDIV_SIGNED_EN
    eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFFD;
    eh[2] = 32'h1;        el[2] = 32'hFFFFFFFD;
    eh[3] = 32'h0;        el[3] = 32'h80000000;
`else
    eh[0] = 32'h1;        el[0] = 32'h7FFFFFFC;
    eh[2] = 32'h7;        el[2] = 32'h0;
    eh[3] = 32'h80000000; el[3] = 32'h0;
`endif
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, vs[i], va[i], vb[i], lat);
      checks++; if (lat !== 34) begin errors++; $display("FAIL div%0d_latency got %0d want 34", i, lat); end
      checks++; if (hi !== eh[i] || lo !== el[i]) begin errors++; $display("FAIL div%0d_result rem/quo got %h/%h want %h/%h", i, hi, lo, eh[i], el[i]); end
      checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL div%0d_div0 got %b want 0", i, div0); end
      @(negedge clock);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    do_op(1'b1, 1'b0, 32'h451, 32'h20, lat);
    @(negedge clock);
    do_op(1'b1, 1'b1, 32'd5, 32'd0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency got %0d want 1", lat); end
    checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_flag got %b want 1", div0); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL div0_hold got %h/%h want 11/22", hi, lo); end
    @(negedge clock);
    checks++; if ({busy, done, div0} !== 3'b000) begin errors++; $display("FAIL div0_end got %b want 000", {busy, done, div0}); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL div0_after got %h/%h want 11/22", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int lat;
    do_op(1'b1, 1'b0, 32'h451, 32'h20, lat);
    @(negedge clock);
    op = 1'b0; sign = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    op = 1'b1; sign = 1'b1; a = 32'hDEADBEEF; b = 32'h0;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (n == 4) begin start = 1'b1; a = 32'd9; end
      if (n == 5) start = 1'b0;
      if (n == 10) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL b2b_hold_run got %h/%h want 11/22", hi, lo); end
      end
      if (done) begin lat = n + 1; break; end
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", lat); end
    checks++; if (hi !== 32'h0 || lo !== 32'd15) begin errors++; $display("FAIL b2b_result got %h_%h want 0_f", hi, lo); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy got %b want 0", busy); end
  endtask

  task automatic test_abort;
    int lat;
    int seen;
    do_op(1'b1, 1'b0, 32'h451, 32'h20, lat);
    @(negedge clock);
    op = 1'b0; sign = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (done) seen++;
      if (n == 4) start = 1'b1;
      if (n == 5) start = 1'b0;
      if (n == 9) reset = 1'b1;
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL abort_hilo got %h/%h want 0/0", hi, lo); end
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (even, >= 4).
REQ-002 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port op  input  1  0 = multiply, 1 = divide.
REQ-006 Port sign  input  1  1 = signed two's-complement operands, 0 = unsigned.
REQ-007 Port a  input  WIDTH  multiplicand / dividend.
REQ-008 Port b  input  WIDTH  multiplier / divisor.
REQ-009 Port busy  output  1  high while an operation is in flight (any state other than IDLE).
REQ-010 Port done  output  1  one-cycle completion pulse.
REQ-011 Port div0  output  1  one-cycle pulse, coincident with done, on divide by zero.
REQ-012 Port hi  output  WIDTH  product high word / remainder.
REQ-013 Port lo  output  WIDTH  product low word / quotient.

Function
REQ-014 States SHALL be IDLE, PREP, RUN and FIX; each transition takes one clock edge.
REQ-015 IDLE with start=1: a, b, op and sign SHALL be latched, and the state SHALL go to PREP.
REQ-016 Exception: IDLE with start=1, op=1 and b=0 SHALL go to FIX with the zero-divisor flag set.
REQ-017 PREP SHALL convert latched operands to magnitudes when sign=1, record result signs, clear the accumulator, load the iteration counter with WIDTH, then go to RUN.
REQ-018 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-019 RUN SHALL decrement the counter each step and go to FIX after exactly WIDTH steps.
REQ-020 FIX SHALL negate the results as required, write hi/lo, assert done for one cycle, then return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle after the (WIDTH+2)th edge counted from the edge that samples start; this is 34 cycles for WIDTH=32.
REQ-022 Multiply: {hi,lo} SHALL equal the full 2*WIDTH-bit product, signed or unsigned per sign.
REQ-023 Divide: lo SHALL hold the quotient truncated toward zero; hi SHALL hold the remainder, which takes the sign of the dividend.
REQ-024 Signed most-negative / -1 SHALL return lo = most-negative value and hi = 0, with no flag raised.
REQ-025 Divide by zero: done and div0 SHALL pulse one cycle after start is sampled; hi and lo SHALL remain unchanged.
REQ-026 start while busy=1 SHALL be ignored, and operands SHALL not be re-latched.
REQ-027 hi and lo SHALL hold their last values until the next FIX or reset; they SHALL not change during RUN.
REQ-028 Input changes on a, b, op and sign after start is sampled SHALL not affect the result.

Reset
REQ-029 With reset=1 at a clock edge: state -> IDLE; busy=0, done=0, div0=0, hi=0, lo=0; counter and accumulators cleared.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-031 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-032 Macro MULDIV_SIGNED_EN: when defined, the sign input SHALL be honoured as in REQ-006 and REQ-017 to REQ-024.
REQ-033 When MULDIV_SIGNED_EN is undefined, sign SHALL be ignored, all operations SHALL be unsigned, and the negate/fixup logic SHALL be absent.
REQ-034 In both configurations, FIX SHALL still occupy one cycle so that latency is unchanged.

Verification (WIDTH=32, MULDIV_SIGNED_EN defined unless stated)
REQ-035 op=0, sign=1, a=7, b=0xFFFFFFFD -> after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy falls the following cycle.
REQ-036 op=0, sign=0, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 op=1, sign=1, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; the same operands with sign=0 -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-038 op=1, a=5, b=0, with hi/lo previously 0x11/0x22 -> done=div0=1 one cycle after start; hi=0x11, lo=0x22 unchanged.
REQ-039 op=1, sign=1, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
REQ-040 Start a multiply; pulse start again at cycle 5 -> the second start is ignored; assert reset at cycle 10 -> busy=0, hi=lo=0, and no done pulse appears.
